// File: rtl/minmax_reduce.sv
// Frame-wise min/max reduction with per-frame mode, MAX_LEN truncation and a held result.
// Optional macro MINMAX_REDUCE_INDEX_EN adds out_index (position of the winning element).
module minmax_reduce #(
  parameter int WIDTH     = 32,
  parameter int MAX_LEN   = 256,
  parameter int IS_SIGNED = 0,
  parameter int IMPL_TYPE = 0,
  localparam int IDX_W    = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_max,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W:0]   out_count,
`ifdef MINMAX_REDUCE_INDEX_EN
  output logic [IDX_W-1:0] out_index,
`endif
  output logic             out_trunc
);

  // state   | meaning
  // S_IDLE  | no element of the current frame yet
  // S_ACCUM | frame open, accumulating
  // S_DONE  | result held until the consumer accepts it
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LEN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             mode_q, mode_d;
  logic             trunc_q, trunc_d;
`ifdef MINMAX_REDUCE_INDEX_EN
  logic [IDX_W-1:0] index_q, index_d;
`endif

  logic           in_gt, in_lt;
  logic [IDX_W:0] count_inc;

  assign count_inc = count_q + 1'b1;

  // Both comparator styles give identical results; only the structure differs.
  generate
    if (IMPL_TYPE == 0) begin : g_rel
      if (IS_SIGNED != 0) begin : g_s
        assign in_gt = $signed(in_data) > $signed(acc_q);
        assign in_lt = $signed(in_data) < $signed(acc_q);
      end else begin : g_u
        assign in_gt = in_data > acc_q;
        assign in_lt = in_data < acc_q;
      end
    end else begin : g_sub
      // Flipping the sign bit maps two's complement order onto unsigned order.
      localparam logic [WIDTH-1:0] FLIP = (IS_SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
      logic [WIDTH-1:0] a_k, b_k;
      logic [WIDTH:0]   diff_ba, diff_ab;
      assign a_k     = in_data ^ FLIP;
      assign b_k     = acc_q ^ FLIP;
      assign diff_ba = {1'b0, b_k} - {1'b0, a_k};
      assign diff_ab = {1'b0, a_k} - {1'b0, b_k};
      assign in_gt   = diff_ba[WIDTH];
      assign in_lt   = diff_ab[WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      trunc_q <= 1'b0;
`ifdef MINMAX_REDUCE_INDEX_EN
      index_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      trunc_q <= trunc_d;
`ifdef MINMAX_REDUCE_INDEX_EN
      index_q <= index_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    trunc_d = trunc_q;
`ifdef MINMAX_REDUCE_INDEX_EN
    index_d = index_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          count_d = (IDX_W+1)'(1);
          mode_d  = mode_max;
          trunc_d = 1'b0;
`ifdef MINMAX_REDUCE_INDEX_EN
          index_d = '0;
`endif
          state_d = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          // Strict compare keeps the earliest element on ties.
          if (mode_q ? in_gt : in_lt) begin
            acc_d = in_data;
`ifdef MINMAX_REDUCE_INDEX_EN
            index_d = count_q[IDX_W-1:0];
`endif
          end
          count_d = count_inc;
          if (in_last || (count_inc == MAX_CNT)) begin
            state_d = S_DONE;
            trunc_d = !in_last;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
    out_data  = acc_q;
    out_count = count_q;
    out_trunc = trunc_q;
`ifdef MINMAX_REDUCE_INDEX_EN
    out_index = index_q;
`endif
  end

endmodule

// File: doc/minmax_reduce.md
MINMAX_REDUCE -- requirements
Module: minmax_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the element width in bits.
REQ-002 SHALL have parameter MAX_LEN, default 256 (>=2), the maximum elements per frame; IDX_W = clog2(MAX_LEN).
REQ-003 SHALL have parameter IS_SIGNED, default 0: 0 compares as unsigned, 1 as two's complement.
REQ-004 SHALL have parameter IMPL_TYPE, default 0, which selects the comparator implementation; it SHALL NOT change function.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports as follows.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 mode_max  in  1  1 = max reduction, 0 = min reduction; sampled on the first beat of each frame.
REQ-009 in_valid  in  1  input element valid.
REQ-010 in_ready  out  1  block can accept an element.
REQ-011 in_data  in  WIDTH  element.
REQ-012 in_last  in  1  final element of the frame.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_data  out  WIDTH  min or max of the frame.
REQ-016 out_count  out  IDX_W+1  number of elements in the frame.
REQ-017 out_trunc  out  1  frame was closed by MAX_LEN rather than by in_last.

Function
REQ-018 A beat SHALL transfer when in_valid && in_ready; a result SHALL transfer when out_valid && out_ready.
REQ-019 The block SHALL use a 3-state FSM: IDLE (no element yet), ACCUM (frame open), DONE (result held).
REQ-020 In IDLE and ACCUM, in_ready=1; in DONE, in_ready=0.
REQ-021 First beat in IDLE:
- load the accumulator with in_data and count with 1;
- latch mode_max;
- go to ACCUM, or to DONE if in_last.
REQ-022 Beat in ACCUM:
- replace the accumulator only if in_data is strictly greater (max) or strictly less (min);
- increment count.
REQ-023 Ties SHALL keep the earliest element.
REQ-024 A beat with in_last, or the beat that makes count equal MAX_LEN, SHALL move the FSM to DONE.
REQ-025 out_trunc=1 SHALL be set only when MAX_LEN closed the frame and in_last was 0 on that beat.
REQ-026 out_valid SHALL be asserted the cycle after the closing beat (latency 1), with out_data, out_count and out_trunc stable until accepted.
REQ-027 A result transfer SHALL return the FSM to IDLE; the next frame's first beat is accepted no earlier than the following cycle.
REQ-028 Changes to mode_max mid-frame SHALL be ignored.
REQ-029 The comparison SHALL honour IS_SIGNED; with IS_SIGNED=1 and WIDTH=32, 32'h8000_0000 is the minimum.
REQ-030 A single-element frame SHALL return that element with out_count=1.

Reset
REQ-031 When rst_n=0 at a clock edge:
- FSM → IDLE;
- out_valid=0, out_data=0, out_count=0, out_trunc=0, out_index=0;
- in_ready=1 from the first cycle after reset.
REQ-032 Reset mid-frame or while in DONE SHALL discard all partial and held results.

Configuration
REQ-033 With macro MINMAX_REDUCE_INDEX_EN defined:
- port out_index (out, IDX_W) SHALL exist;
- it gives the zero-based position in the frame of the winning element (earliest on ties);
- it is valid with out_valid.
REQ-034 Without MINMAX_REDUCE_INDEX_EN, the out_index port and its register SHALL be absent; all other behaviour is unchanged.

Verification
REQ-035 Unsigned max: frame 5,9,9,2 (last on 2), mode_max=1 → out_data=9, out_count=4, out_trunc=0, out_index=1.
REQ-036 Signed min: IS_SIGNED=1, frame 3, 0xFFFF_FFFE, 7, mode_max=0 → out_data=0xFFFF_FFFE, out_index=1.
REQ-037 Truncation: MAX_LEN=4, feed 6 beats with no in_last:
- first result out_count=4, out_trunc=1;
- in_ready=0 until the result is accepted;
- remaining 2 beats form the next frame.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles after the result → out_valid stays 1, outputs are stable, in_ready=0; they release on acceptance.
REQ-039 Reset mid-frame: rst_n=0 after 2 beats → out_valid=0 and in_ready=1 afterwards; a new frame of single element 42 → out_data=42, out_count=1.
REQ-040 Mode change mid-frame: mode_max=1 at the first beat, toggled to 0 on later beats of frame 1,4,2 → out_data=4.
